// File: rtl/memory_port.sv
// Bus controller between the CPU and a word-organised RAM: byte/halfword/word
// loads and stores over req/ack, read-modify-write for sub-word stores, programmable wait states.
`timescale 1ns/1ps
module memory_port #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [16:0] cpu_address,
    input  logic [1:0]  lane,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ack,
    output logic        busy,
    output logic [16:0] mem_address,
    output logic        mem_write_en,
    output logic [31:0] mem_data_out,
    input  logic [31:0] mem_data_in
);

    typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

    state_t      state;
    state_t      state_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic [3:0]  count;
    logic        accept;

    // Bit 31 is big-endian bit 0, so byte lane 0 is the most significant byte.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] ln);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (ln)
                2'd0:    r = {24'h0, w[31:24]};
                2'd1:    r = {24'h0, w[23:16]};
                2'd2:    r = {24'h0, w[15:8]};
                default: r = {24'h0, w[7:0]};
            endcase
        end else if (sz == 2'b01) begin
            r = ln[1] ? {16'h0, w[15:0]} : {16'h0, w[31:16]};
        end
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] d,
                                          input logic [1:0] sz, input logic [1:0] ln);
        logic [31:0] r;
        r = w;
        if (sz == 2'b00) begin
            case (ln)
                2'd0:    r[31:24] = d[7:0];
                2'd1:    r[23:16] = d[7:0];
                2'd2:    r[15:8]  = d[7:0];
                default: r[7:0]   = d[7:0];
            endcase
        end else if (sz == 2'b01) begin
            if (ln[1]) r[15:0] = d;
            else       r[31:16] = d;
        end
        return r;
    endfunction

    // A request still held at the end of ACK is taken at that same edge.
    assign accept = req && (state == IDLE || state == ACK);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ACK: begin
                if (req) state_next = (we && size[1]) ? WR : RD;
                else     state_next = IDLE;
            end
            RD: begin
                if (count == 4'd0) state_next = we_q ? WR : ACK;
            end
            WR:      state_next = ACK;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack          = (state == ACK);
        busy         = (state != IDLE);
        mem_write_en = (state == WR) && !reset;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            count        <= 4'd0;
            cpu_rdata    <= 32'h0;
            mem_address  <= 17'h0;
            mem_data_out <= 32'h0;
        end else if (accept) begin
            we_q        <= we;
            size_q      <= size;
            lane_q      <= lane;
            wdata_q     <= cpu_wdata[15:0];
            mem_address <= cpu_address;
            count       <= 4'(WAIT_STATES);
            if (we && size[1]) mem_data_out <= cpu_wdata;
        end else if (state == RD) begin
            if (count != 4'd0)  count        <= count - 4'd1;
            else if (!we_q)     cpu_rdata    <= extract(mem_data_in, size_q, lane_q);
            else                mem_data_out <= merge(mem_data_in, wdata_q, size_q, lane_q);
        end
    end

endmodule

// File: tb/tb_memory_port.sv
// Directed bench for memory_port with WAIT_STATES=1 against a 128-word RAM model.
`timescale 1ns/1ps
module tb_memory_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [16:0] cpu_address;
    logic [1:0]  lane;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        ack;
    logic        busy;
    logic [16:0] mem_address;
    logic        mem_write_en;
    logic [31:0] mem_data_out;
    logic [31:0] mem_data_in;

    logic [31:0] ram [128];
    int errors = 0;
    int checks = 0;

    logic [11:0] busy_t;
    logic [11:0] ack_t;
    logic [11:0] we_t;
    logic        any_ack;

    memory_port #(.WAIT_STATES(1)) dut (
        .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
        .cpu_address(cpu_address), .lane(lane), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .ack(ack), .busy(busy), .mem_address(mem_address),
        .mem_write_en(mem_write_en), .mem_data_out(mem_data_out), .mem_data_in(mem_data_in)
    );

    always #5 clock = ~clock;

    assign mem_data_in = ram[mem_address[6:0]];
    always @(posedge clock) if (mem_write_en) ram[mem_address[6:0]] <= mem_data_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request at E0, drop req, then trace 12 cycles (bit k = cycle after E0+k).
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic [16:0] a,
                           input logic [1:0] ln, input logic [31:0] d,
                           output logic [11:0] bt, output logic [11:0] at, output logic [11:0] wt);
        we = w; size = sz; cpu_address = a; lane = ln; cpu_wdata = d; req = 1'b1;
        step();
        req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bt[k] = busy;
            at[k] = ack;
            wt[k] = mem_write_en;
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        ram[5] = 32'h12345678;
        ram[7] = 32'hAABBCCDD;
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
        cpu_address = 17'h0; lane = 2'b00; cpu_wdata = 32'h0;
        step();
        step();
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_we", {31'h0, mem_write_en}, 32'h0);
        check("rst_addr", {15'h0, mem_address}, 32'h0);
        check("rst_dout", mem_data_out, 32'h0);
        reset = 1'b0;
        step();

        run_txn(1'b0, 2'b10, 17'd5, 2'd0, 32'h0, busy_t, ack_t, we_t);
        check("word_rd_busy", {20'h0, busy_t}, 32'h007);
        check("word_rd_ack", {20'h0, ack_t}, 32'h004);
        check("word_rd_we", {20'h0, we_t}, 32'h000);
        check("word_rd_data", cpu_rdata, 32'h12345678);

        run_txn(1'b0, 2'b00, 17'd5, 2'd2, 32'h0, busy_t, ack_t, we_t);
        check("byte_rd_ack", {20'h0, ack_t}, 32'h004);
        check("byte_rd_l2", cpu_rdata, 32'h00000056);

        run_txn(1'b0, 2'b00, 17'd5, 2'd0, 32'h0, busy_t, ack_t, we_t);
        check("byte_rd_l0", cpu_rdata, 32'h00000012);

        run_txn(1'b0, 2'b01, 17'd5, 2'd0, 32'h0, busy_t, ack_t, we_t);
        check("half_rd_l0", cpu_rdata, 32'h00001234);
        run_txn(1'b0, 2'b01, 17'd5, 2'd2, 32'h0, busy_t, ack_t, we_t);
        check("half_rd_l2", cpu_rdata, 32'h00005678);
        run_txn(1'b0, 2'b01, 17'd5, 2'd1, 32'h0, busy_t, ack_t, we_t);
        check("half_rd_l1", cpu_rdata, 32'h00001234);

        run_txn(1'b1, 2'b00, 17'd7, 2'd1, 32'hFFFFFF11, busy_t, ack_t, we_t);
        check("byte_wr_busy", {20'h0, busy_t}, 32'h00F);
        check("byte_wr_ack", {20'h0, ack_t}, 32'h008);
        check("byte_wr_we", {20'h0, we_t}, 32'h004);
        check("byte_wr_dout", mem_data_out, 32'hAA11CCDD);
        check("byte_wr_ram", ram[7], 32'hAA11CCDD);
        check("byte_wr_rdata_held", cpu_rdata, 32'h00001234);

        // Word write with req held through ACK: second write follows without an idle cycle.
        we = 1'b1; size = 2'b10; cpu_address = 17'd9; lane = 2'd0;
        cpu_wdata = 32'hCAFEF00D; req = 1'b1;
        step();
        busy_t = '0; ack_t = '0; we_t = '0;
        for (int k = 0; k < 6; k++) begin
            busy_t[k] = busy;
            ack_t[k] = ack;
            we_t[k] = mem_write_en;
            if (k == 1) begin
                check("word_wr_ram_early", ram[9], 32'hCAFEF00D);
                cpu_address = 17'd10;
                cpu_wdata = 32'h11111111;
            end
            if (k == 3) req = 1'b0;
            step();
        end
        check("b2b_busy", {20'h0, busy_t}, 32'h00F);
        check("b2b_ack", {20'h0, ack_t}, 32'h00A);
        check("b2b_we", {20'h0, we_t}, 32'h005);
        check("b2b_ram9", ram[9], 32'hCAFEF00D);
        check("b2b_ram10", ram[10], 32'h11111111);

        // Reset in the middle of a read.
        we = 1'b0; size = 2'b10; cpu_address = 17'd5; req = 1'b1;
        step();
        req = 1'b0;
        reset = 1'b1;
        step();
        step();
        check("rdrst_rdata", cpu_rdata, 32'h0);
        check("rdrst_busy", {31'h0, busy}, 32'h0);
        check("rdrst_addr", {15'h0, mem_address}, 32'h0);
        check("rdrst_dout", mem_data_out, 32'h0);
        reset = 1'b0;
        any_ack = 1'b0;
        for (int k = 0; k < 5; k++) begin
            any_ack |= ack;
            step();
        end
        check("rdrst_no_ack", {31'h0, any_ack}, 32'h0);

        // Reset while a halfword write is in WR.
        we = 1'b1; size = 2'b01; cpu_address = 17'd7; lane = 2'd0;
        cpu_wdata = 32'h0000BEEF; req = 1'b1;
        step();
        req = 1'b0;
        step();
        step();
        check("hwrst_we_before", {31'h0, mem_write_en}, 32'h1);
        check("hwrst_dout", mem_data_out, 32'hBEEFCCDD);
        reset = 1'b1;
        #1;
        check("hwrst_we_suppressed", {31'h0, mem_write_en}, 32'h0);
        step();
        step();
        reset = 1'b0;
        any_ack = ack;
        check("hwrst_busy", {31'h0, busy}, 32'h0);
        for (int k = 0; k < 5; k++) begin
            any_ack |= ack;
            step();
        end
        check("hwrst_no_ack", {31'h0, any_ack}, 32'h0);
        check("hwrst_ram", ram[7], 32'hAA11CCDD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
